// File: rtl/mcp_controller_if.sv
// rtl/mcp_controller_if.sv - instruction/data memory request/ready handshake bundle
interface mcp_controller_if;
  logic imem_req_o;
  logic imem_ready_i;
  logic dmem_req_o;
  logic dmem_we_o;
  logic dmem_ready_i;

  modport master (
    output imem_req_o,
    input  imem_ready_i,
    output dmem_req_o,
    output dmem_we_o,
    input  dmem_ready_i
  );

  modport slave (
    input  imem_req_o,
    output imem_ready_i,
    input  dmem_req_o,
    input  dmem_we_o,
    output dmem_ready_i
  );
endinterface

// File: rtl/mcp_controller.sv
// rtl/mcp_controller.sv - multi-cycle RV32I control unit with stall-tolerant memory handshakes,
// illegal-opcode/timeout traps and a retired-instruction counter
module mcp_controller #(
  parameter int X_LEN    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mcp_controller_if.master mem,
  input  logic [X_LEN-1:0] instr_i,
  input  logic [X_LEN-1:0] rs1_data_i,
  input  logic [X_LEN-1:0] rs2_data_i,
  output logic             IR_WE_o,
  output logic             PC_WE_o,
  output logic [1:0]       PC_SEL_o,
  output logic [2:0]       IMM_SEL_o,
  output logic             REG_WRITE_o,
  output logic             A_SEL_o,
  output logic             B_SEL_o,
  output logic [3:0]       ALU_OP_o,
  output logic [1:0]       WB_SEL_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [X_LEN-1:0] instret_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] W_LAST = CW'(MAX_WAIT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_wait;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_next;
  logic [X_LEN-1:0] r_instret;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_legal;
  logic       w_taken;
  logic [2:0] w_imm_sel;
  logic [3:0] w_f3_alu;
  logic [3:0] w_alu_op;
  logic       w_a_sel;
  logic       w_b_sel;
  logic       w_imem_req;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_unused;

  assign w_opcode = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_unused = ^{instr_i[X_LEN-1:31], instr_i[29:15], instr_i[11:7]};

  always_comb begin
    w_legal   = 1'b1;
    w_imm_sel = 3'b000;
    case (w_opcode)
      OP_R, OP_I, OP_LOAD, OP_JALR: w_imm_sel = 3'b000;
      OP_STORE:                     w_imm_sel = 3'b001;
      OP_BRANCH: begin
        w_imm_sel = 3'b010;
        w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      OP_LUI, OP_AUIPC:             w_imm_sel = 3'b011;
      OP_JAL:                       w_imm_sel = 3'b100;
      default:                      w_legal   = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (rs1_data_i == rs2_data_i);
      3'b001:  w_taken = (rs1_data_i != rs2_data_i);
      3'b100:  w_taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
      3'b101:  w_taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  w_taken = (rs1_data_i <  rs2_data_i);
      3'b111:  w_taken = (rs1_data_i >= rs2_data_i);
      default: w_taken = 1'b0;
    endcase
  end

  // instr_i[30] selects SUB only for register-register ops; for ADDI it is an immediate bit.
  always_comb begin
    w_f3_alu = 4'b0000;
    case (w_f3)
      3'b000:  w_f3_alu = (w_opcode == OP_R && instr_i[30]) ? 4'b0001 : 4'b0000;
      3'b001:  w_f3_alu = 4'b0101;
      3'b010:  w_f3_alu = 4'b1000;
      3'b011:  w_f3_alu = 4'b1001;
      3'b100:  w_f3_alu = 4'b0100;
      3'b101:  w_f3_alu = instr_i[30] ? 4'b0111 : 4'b0110;
      3'b110:  w_f3_alu = 4'b1010;
      default: w_f3_alu = 4'b1011;
    endcase
  end

  always_comb begin
    w_alu_op = 4'b0000;
    w_a_sel  = 1'b0;
    w_b_sel  = 1'b0;
    case (w_opcode)
      OP_R:                         w_alu_op = w_f3_alu;
      OP_I: begin
        w_alu_op = w_f3_alu;
        w_b_sel  = 1'b1;
      end
      OP_LUI: begin
        w_alu_op = 4'b1100;
        w_b_sel  = 1'b1;
      end
      OP_AUIPC, OP_JAL, OP_BRANCH: begin
        w_a_sel = 1'b1;
        w_b_sel = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_JALR:   w_b_sel = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    IR_WE_o      = 1'b0;
    PC_WE_o      = 1'b0;
    PC_SEL_o     = 2'b00;
    IMM_SEL_o    = 3'b000;
    REG_WRITE_o  = 1'b0;
    A_SEL_o      = 1'b0;
    B_SEL_o      = 1'b0;
    ALU_OP_o     = 4'b0000;
    WB_SEL_o     = 2'b00;
    trap_o       = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (mem.imem_ready_i) begin
          IR_WE_o = 1'b1;
          w_next  = S_DECODE;
        end else if (r_wait == W_LAST) begin
          w_next       = S_TRAP;
          w_cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        IMM_SEL_o = w_imm_sel;
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next       = S_TRAP;
          w_cause_next = 2'b01;
        end
      end
      S_EXEC: begin
        ALU_OP_o = w_alu_op;
        A_SEL_o  = w_a_sel;
        B_SEL_o  = w_b_sel;
        if (w_opcode == OP_BRANCH) begin
          PC_WE_o  = 1'b1;
          PC_SEL_o = w_taken ? 2'b01 : 2'b00;
          w_next   = S_FETCH;
        end else if (w_opcode == OP_LOAD || w_opcode == OP_STORE) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        ALU_OP_o   = w_alu_op;
        A_SEL_o    = w_a_sel;
        B_SEL_o    = w_b_sel;
        w_dmem_req = 1'b1;
        w_dmem_we  = (w_opcode == OP_STORE);
        if (mem.dmem_ready_i) begin
          if (w_opcode == OP_STORE) begin
            PC_WE_o = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (r_wait == W_LAST) begin
          w_next       = S_TRAP;
          w_cause_next = 2'b11;
        end
      end
      S_WB: begin
        ALU_OP_o    = w_alu_op;
        A_SEL_o     = w_a_sel;
        B_SEL_o     = w_b_sel;
        REG_WRITE_o = 1'b1;
        PC_WE_o     = 1'b1;
        w_next      = S_FETCH;
        if (w_opcode == OP_LOAD) begin
          WB_SEL_o = 2'b01;
        end else if (w_opcode == OP_JAL) begin
          WB_SEL_o = 2'b10;
          PC_SEL_o = 2'b01;
        end else if (w_opcode == OP_JALR) begin
          WB_SEL_o = 2'b10;
          PC_SEL_o = 2'b10;
        end
      end
      S_TRAP: trap_o = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_cause   <= 2'b00;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (w_next != r_state && (w_next == S_FETCH || w_next == S_MEM)) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH && !mem.imem_ready_i) ||
                   (r_state == S_MEM && !mem.dmem_ready_i)) begin
        r_wait <= r_wait + 1'b1;
      end
      if (PC_WE_o) begin
        r_instret <= r_instret + 1'b1;
      end
    end
  end

  assign mem.imem_req_o = w_imem_req;
  assign mem.dmem_req_o = w_dmem_req;
  assign mem.dmem_we_o  = w_dmem_we;
  assign trap_cause_o   = r_cause;
  assign instret_o      = r_instret;

endmodule

// File: tb/tb_mcp_controller.sv
// tb/tb_mcp_controller.sv - randomized scoreboard bench for mcp_controller
module tb_mcp_controller;
  localparam int X_LEN    = 32;
  localparam int MAX_WAIT = 15;

  typedef struct {
    bit         trap;
    logic [1:0] cause;
    int         lat;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       rw;
    logic [3:0] alu;
    logic       a_sel;
    logic       b_sel;
    logic [2:0] imm;
    int         dcyc;
    logic       dwe;
  } exp_t;

  localparam logic [3:0] F3_ALU [8] = '{4'b0000, 4'b0101, 4'b1000, 4'b1001,
                                        4'b0100, 4'b0110, 4'b1010, 4'b1011};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [X_LEN-1:0]  instr = '0;
  logic [X_LEN-1:0]  rs1 = '0;
  logic [X_LEN-1:0]  rs2 = '0;
  logic              ir_we, pc_we, reg_write, a_sel, b_sel, trap;
  logic [1:0]        pc_sel, wb_sel, cause;
  logic [2:0]        imm_sel;
  logic [3:0]        alu_op;
  logic [X_LEN-1:0]  instret;

  mcp_controller_if mem();

  mcp_controller #(.X_LEN(X_LEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem(mem),
    .instr_i(instr), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .IR_WE_o(ir_we), .PC_WE_o(pc_we), .PC_SEL_o(pc_sel), .IMM_SEL_o(imm_sel),
    .REG_WRITE_o(reg_write), .A_SEL_o(a_sel), .B_SEL_o(b_sel), .ALU_OP_o(alu_op),
    .WB_SEL_o(wb_sel), .trap_o(trap), .trap_cause_o(cause), .instret_o(instret)
  );

  always #5 clk = ~clk;

  wire [18:0] ctl_vec = {mem.imem_req_o, mem.dmem_req_o, mem.dmem_we_o, ir_we, pc_we, pc_sel,
                         imm_sel, reg_write, a_sel, b_sel, alu_op, wb_sel};

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   retire_cnt = 0;
  bit   trap_seen = 0;
  int   exp_instret = 0;
  int   istall_n = 0;
  int   dstall_n = 0;
  int   icnt = 0;
  int   dcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: spec rules expressed per instruction as total latency and retire-time controls.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                 input int ist, input int dst);
    exp_t e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    e = '{default: 0};
    e.lat = 2 + ist;
    case (op)
      7'b0110011, 7'b0010011: begin
        e.alu = F3_ALU[f3];
        if (f3 == 3'b101 && ins[30]) e.alu = 4'b0111;
        if (op == 7'b0110011 && f3 == 3'b000 && ins[30]) e.alu = 4'b0001;
        e.b_sel = (op == 7'b0010011);
        e.rw = 1; e.lat += 2;
      end
      7'b0000011: begin
        e.b_sel = 1; e.rw = 1; e.wb_sel = 2'b01; e.dcyc = 1 + dst; e.lat += 3 + dst;
        if (dst >= MAX_WAIT) begin e = '{default: 0}; e.trap = 1; e.cause = 2'b11; e.lat = 4 + ist + MAX_WAIT - 1; end
      end
      7'b0100011: begin
        e.b_sel = 1; e.imm = 3'b001; e.dcyc = 1 + dst; e.dwe = 1; e.lat += 2 + dst;
        if (dst >= MAX_WAIT) begin e = '{default: 0}; e.trap = 1; e.cause = 2'b11; e.lat = 4 + ist + MAX_WAIT - 1; end
      end
      7'b1100011: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          e.trap = 1; e.cause = 2'b01;
        end else begin
          e.a_sel = 1; e.b_sel = 1; e.imm = 3'b010; e.lat += 1;
          case (f3)
            3'b000:  e.pc_sel = (a == b) ? 2'b01 : 2'b00;
            3'b001:  e.pc_sel = (a != b) ? 2'b01 : 2'b00;
            3'b100:  e.pc_sel = ($signed(a) < $signed(b)) ? 2'b01 : 2'b00;
            3'b101:  e.pc_sel = ($signed(a) >= $signed(b)) ? 2'b01 : 2'b00;
            3'b110:  e.pc_sel = (a < b) ? 2'b01 : 2'b00;
            default: e.pc_sel = (a >= b) ? 2'b01 : 2'b00;
          endcase
        end
      end
      7'b1101111: begin e.a_sel = 1; e.b_sel = 1; e.imm = 3'b100; e.wb_sel = 2'b10; e.pc_sel = 2'b01; e.rw = 1; e.lat += 2; end
      7'b1100111: begin e.b_sel = 1; e.wb_sel = 2'b10; e.pc_sel = 2'b10; e.rw = 1; e.lat += 2; end
      7'b0110111: begin e.alu = 4'b1100; e.b_sel = 1; e.imm = 3'b011; e.rw = 1; e.lat += 2; end
      7'b0010111: begin e.a_sel = 1; e.b_sel = 1; e.imm = 3'b011; e.rw = 1; e.lat += 2; end
      default: begin e.trap = 1; e.cause = 2'b01; end
    endcase
    if (ist >= MAX_WAIT) begin
      e = '{default: 0}; e.trap = 1; e.cause = 2'b10; e.lat = MAX_WAIT;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mem.imem_req_o) begin mem.imem_ready_i = (icnt >= istall_n); icnt++; end
    else begin mem.imem_ready_i = 1'b0; icnt = 0; end
    if (mem.dmem_req_o) begin mem.dmem_ready_i = (dcnt >= dstall_n); dcnt++; end
    else begin mem.dmem_ready_i = 1'b0; dcnt = 0; end
  end

  bit         active = 0;
  bit         prev_irwe = 0;
  int         lat, irwe_n, dcyc;
  logic       dwe_seen, rw_seen;
  logic [2:0] imm_cap;

  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst_n) begin
      active = 0; prev_irwe = 0;
    end else begin
      if (!active && mem.imem_req_o) begin
        active = 1; lat = 0; irwe_n = 0; dcyc = 0; dwe_seen = 0; rw_seen = 0; imm_cap = 0; prev_irwe = 0;
      end
      if (active && trap) begin
        active = 0; trap_seen = 1;
        if (q.size() == 0) check("unexpected_trap", 1, 0);
        else begin
          e = q.pop_front();
          check("trap_expected", 1, e.trap);
          check("trap_cause", cause, e.cause);
          check("trap_latency", lat, e.lat);
          check("trap_ctl_zero", ctl_vec, 0);
        end
      end else if (active) begin
        lat++;
        if (prev_irwe) imm_cap = imm_sel;
        prev_irwe = ir_we;
        if (ir_we) irwe_n++;
        if (mem.dmem_req_o) dcyc++;
        if (mem.dmem_we_o) dwe_seen = 1;
        if (reg_write) rw_seen = 1;
        if (pc_we) begin
          active = 0; retire_cnt++;
          if (q.size() == 0) check("unexpected_retire", 1, 0);
          else begin
            e = q.pop_front();
            check("retire_not_trap", 0, e.trap);
            check("latency", lat, e.lat);
            check("pc_sel", pc_sel, e.pc_sel);
            check("wb_sel", wb_sel, e.wb_sel);
            check("reg_write", rw_seen, e.rw);
            check("alu_op", alu_op, e.alu);
            check("a_sel", a_sel, e.a_sel);
            check("b_sel", b_sel, e.b_sel);
            check("imm_sel", imm_cap, e.imm);
            check("dmem_cycles", dcyc, e.dcyc);
            check("dmem_we", dwe_seen, e.dwe);
            check("ir_we_once", irwe_n, 1);
            check("instret", instret, exp_instret);
            exp_instret++;
          end
        end
      end
    end
  end

  task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                     input int ist, input int dst, output exp_t e);
    int start;
    instr = ins; rs1 = a; rs2 = b; istall_n = ist; dstall_n = dst; trap_seen = 0;
    e = model(ins, a, b, ist, dst);
    q.push_back(e);
    start = retire_cnt;
    for (int k = 0; k < 400 && retire_cnt == start && !trap_seen; k++) @(posedge clk);
    check("instr_done", (retire_cnt != start) || trap_seen, 1);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_ctl_zero", ctl_vec, 0);
    check("rst_trap", {trap, cause}, 0);
    check("rst_instret", instret, 0);
    q.delete(); exp_instret = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic trap_hold(input logic [1:0] c);
    repeat (4) begin
      @(negedge clk); #2;
      check("trap_hold", {trap, cause, ctl_vec}, {1'b1, c, 19'd0});
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    logic [2:0]  f3 = r[14:12];
    case ($urandom_range(0, 8))
      0: begin r[6:0] = 7'b0110011; r[31:25] = ((f3 == 3'b000 || f3 == 3'b101) && r[30]) ? 7'b0100000 : 7'b0; end
      1: begin
        r[6:0] = 7'b0010011;
        if (f3 == 3'b001) r[31:25] = 7'b0;
        if (f3 == 3'b101) r[31:25] = r[30] ? 7'b0100000 : 7'b0;
      end
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: begin r[6:0] = 7'b1100011; if (f3 == 3'b010 || f3 == 3'b011) r[14:12] = {1'b1, f3[1:0]}; end
      5: r[6:0] = 7'b1101111;
      6: begin r[6:0] = 7'b1100111; r[14:12] = 3'b000; end
      7: r[6:0] = 7'b0110111;
      default: r[6:0] = 7'b0010111;
    endcase
    return r;
  endfunction

  initial begin : stim
    exp_t e;
    logic [31:0] a, b;
    mem.imem_ready_i = 1'b0;
    mem.dmem_ready_i = 1'b0;
    #7;
    check("rst_ctl_zero", ctl_vec, 0);
    check("rst_trap", {trap, cause}, 0);
    check("rst_instret", instret, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    run(32'h002081B3, 0, 0, 0, 0, e);
    run(32'h00208063, 5, 5, 0, 0, e);
    run(32'h00209063, 5, 5, 0, 0, e);
    run(32'h00012083, 0, 0, 0, 2, e);
    run(32'h000080E7, 0, 0, 0, 0, e);
    run(32'h00112023, 0, 0, MAX_WAIT - 1, MAX_WAIT - 1, e);
    run(32'h0020C063, 32'hFFFF_FFFF, 1, 1, 0, e);
    run(32'h0020E063, 32'hFFFF_FFFF, 1, 0, 0, e);

    for (int n = 0; n < 150; n++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      run(rand_instr(), a, b,
          ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : $urandom_range(0, 3),
          ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : $urandom_range(0, 3), e);
    end

    run(32'h0000007F, 0, 0, 0, 0, e);
    trap_hold(2'b01);
    do_reset();
    run(32'h0020A063, 0, 0, 1, 0, e);
    trap_hold(2'b01);
    do_reset();
    run(32'h002081B3, 0, 0, 1000, 0, e);
    trap_hold(2'b10);
    do_reset();
    run(32'h00012083, 0, 0, 0, 1000, e);
    trap_hold(2'b11);
    do_reset();

    instr = 32'h00112023; istall_n = 0; dstall_n = 1000;
    for (int k = 0; k < 50 && !mem.dmem_req_o; k++) @(negedge clk);
    check("abort_reach_mem", mem.dmem_req_o, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("abort_outputs_drop", {mem.dmem_req_o, pc_we, reg_write}, 0);
    q.delete(); exp_instret = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check("abort_instret", instret, 0);
    run(32'h00500093, 0, 0, 0, 0, e);
    run(32'h00500093, 0, 0, 2, 0, e);

    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mcp_controller.md
# mcp_controller

Multi-cycle control unit for the RV32I core: the sequential successor to the single-cycle controller. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states. It handshakes with instruction and data memories that may stall, and it adds JAL/JALR/LUI/AUIPC support, illegal-opcode and memory-timeout traps, and a retired-instruction counter. It sits beside the datapath and drives all register enables and mux selects.

## Interface
- X_LEN, 32, datapath/instruction width
- MAX_WAIT, 15, maximum stall cycles tolerated on a memory request before a fault (≥1)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- instr_i  in  X_LEN  instruction register contents (valid from DECODE onward)
- rs1_data_i, rs2_data_i  in  X_LEN  register-file read data for branch compare
- imem_ready_i  in  1  instruction memory has data this cycle
- dmem_ready_i  in  1  data memory completes the access this cycle
- imem_req_o  out  1  instruction fetch request
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  data access is a store
- IR_WE_o  out  1  load instruction register
- PC_WE_o  out  1  update PC
- PC_SEL_o  out  2  00 PC+4, 01 ALU result, 10 ALU result & ~1
- IMM_SEL_o  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- REG_WRITE_o  out  1  register-file write enable
- A_SEL_o  out  1  0 rs1, 1 PC
- B_SEL_o  out  1  0 rs2, 1 immediate
- ALU_OP_o  out  4  ADD 0000, SUB 0001, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, OR 1010, AND 1011, PASS_B 1100
- WB_SEL_o  out  2  00 ALU, 01 memory, 10 PC+4
- trap_o  out  1  sticky trap indicator
- trap_cause_o  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
- instret_o  out  X_LEN  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state; outputs decoded combinationally from state and instr_i.
- IDLE: entered on reset; all outputs 0; moves to FETCH next cycle.
- FETCH: imem_req_o=1.
  - If imem_ready_i: IR_WE_o=1 in the same cycle, then DECODE.
  - Otherwise hold FETCH.
- DECODE: selects IMM_SEL_o.
  - Opcodes other than 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 go to TRAP with cause 01.
  - Branch func3 010 or 011 also goes to TRAP with cause 01.
  - All other instructions go to EXEC.
- EXEC: ALU controls driven per opcode.
  - R/I-type ALU: funct3 mapping; SUB/SRA/SRAI when instr_i[30]=1. Next state WB.
  - Load/store: ADD, B_SEL=1. Next state MEM.
  - LUI: PASS_B, B_SEL=1. AUIPC: ADD, A_SEL=1, B_SEL=1. Next state WB.
  - JAL: ADD, A_SEL=1, B_SEL=1. JALR: ADD, A_SEL=0, B_SEL=1. Next state WB.
  - Branch: ADD, A_SEL=1, B_SEL=1, PC_WE_o=1. PC_SEL_o=01 if the condition holds (BEQ/BNE/BLT/BGE signed/BLTU/BGEU unsigned), else 00. Retire, then FETCH.
- MEM: dmem_req_o=1; dmem_we_o=1 for stores. ALU controls held as in EXEC.
  - Completes on dmem_ready_i.
  - Store completes with PC_WE_o=1, PC_SEL=00, retire, then FETCH.
  - Load completes to WB.
- WB: REG_WRITE_o=1 and PC_WE_o=1 for one cycle, then retire and go to FETCH.
  - Load: WB_SEL=01.
  - JAL: WB_SEL=10, PC_SEL=01.
  - JALR: WB_SEL=10, PC_SEL=10; ALU controls held as in EXEC.
  - Others: WB_SEL=00, PC_SEL=00.
- Wait counter ($clog2(MAX_WAIT+1) bits): cleared on entry to FETCH or MEM; increments each cycle the request is held without ready. When it reaches MAX_WAIT with ready still low, go to TRAP with cause 10 (FETCH) or 11 (MEM).
- TRAP: trap_o=1; trap_cause_o holds the cause; every other control output is 0. Exited only by reset.
- instret_o: increments by 1 on every cycle where PC_WE_o=1. Wraps modulo 2^X_LEN.

## Timing
- Reset (async assert, sync deassert by the next edge): state IDLE, wait counter 0, instret_o 0, trap_o 0, trap_cause_o 00. All other outputs 0.
- Zero-wait memories (ready high in the request cycle):
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, store: 4 cycles.
  - Load: 5 cycles.
- Each stall cycle adds exactly one cycle. Ready on wait-count MAX_WAIT-1 still completes; no ready after MAX_WAIT stall cycles traps.
- Request signals stay high continuously until ready; no deassert mid-handshake.
- Reset asserted mid-MEM: dmem_req_o drops immediately (async). No PC_WE or REG_WRITE is issued for the aborted instruction.
- instret_o updates on the clock edge closing the retiring cycle.

## Test plan
- Fetch ADD x3,x1,x2 (0x002081B3), zero wait -> IR_WE in cycle 1; WB in cycle 4 with REG_WRITE=1, ALU_OP=0000, WB_SEL=00, PC_SEL=00; instret_o 0->1.
- BEQ with rs1=rs2=5, then BNE with rs1=rs2=5 -> BEQ: EXEC PC_WE=1, PC_SEL=01. BNE: PC_SEL=00. Each takes 3 cycles; no REG_WRITE.
- LW with dmem_ready_i low for 2 cycles -> dmem_req_o high for 3 cycles, then WB with WB_SEL=01. Total 7 cycles.
- JALR (0x000080E7) -> WB: PC_SEL=10, WB_SEL=10, REG_WRITE=1.
- Opcode 0x7F -> TRAP after DECODE, trap_cause_o=01. Outputs stay 0 with trap_o=1 until rst_ni low.
- imem_ready_i never asserts, MAX_WAIT=15 -> TRAP with cause 10 after 15 stall cycles. Then rst_ni pulsed mid-MEM of a later store: no PC_WE, instret_o 0.
